// File: rtl/mtip_stat_pkg.sv
// mtip_stat_pkg: shared constants for the MAC statistics register block.
//   - word addresses of the register map (address bits [9:2])
//   - read-only ID value
//   - event counter index map
//   - access FSM state type
package mtip_stat_pkg;

    localparam logic [7:0] ADDR_ID       = 8'h00;
    localparam logic [7:0] ADDR_STATUS   = 8'h08;
    localparam logic [7:0] ADDR_CTRL     = 8'h09;
    localparam logic [7:0] ADDR_OVF      = 8'h0A;
    localparam logic [7:0] ADDR_CNT_BASE = 8'h10;

    localparam logic [31:0] ID_VALUE = 32'h4D53_0001;

    localparam int unsigned CNT_RX_FRM_RCV     = 0;
    localparam int unsigned CNT_RX_CRC_ERR     = 1;
    localparam int unsigned CNT_RX_FRM_DISCARD = 2;
    localparam int unsigned CNT_RX_LENGTH_ERR  = 3;
    localparam int unsigned CNT_TX_FRM_TRMIT   = 4;
    localparam int unsigned CNT_TX_CRC_ERR     = 5;
    localparam int unsigned CNT_TX_UFLOW_ERR   = 6;
    localparam int unsigned CNT_DEC_ERROR      = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } acc_state_e;

endpackage

// File: rtl/mtip_stat_cnt.sv
// mtip_stat_cnt: one statistics channel.
//   Synchronizes a toggle-encoded event from a foreign clock domain into reg_clk,
//   turns each toggle into a one-cycle increment, and counts it in a saturating
//   counter with a sticky overflow flag.
// Ports:
//   reg_clk, reset_reg_clk  register clock, async active-high reset
//   i_evt_tgl               event toggle (asynchronous)
//   i_clr                   clear counter (clear-all or clear-on-read)
//   i_ovf_clr               W1C strobe for the overflow flag
//   o_cnt                   counter value
//   o_ovf                   sticky overflow flag
module mtip_stat_cnt
    import mtip_stat_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             reg_clk,
    input  logic             reset_reg_clk,
    input  logic             i_evt_tgl,
    input  logic             i_clr,
    input  logic             i_ovf_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovf;
    logic                   w_inc;
    logic                   w_sat;

    always_ff @(posedge reg_clk or posedge reset_reg_clk) begin
        if (reset_reg_clk) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_evt_tgl};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_inc = r_sync[SYNC_STAGES-1] ^ r_hist;
    assign w_sat = &r_cnt;

    // A clear coinciding with an increment leaves 1 so the event is not lost.
    always_ff @(posedge reg_clk or posedge reset_reg_clk) begin
        if (reset_reg_clk) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= w_inc ? CNT_W'(1) : '0;
        end else if (w_inc && !w_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // New saturation beats a simultaneous W1C.
    always_ff @(posedge reg_clk or posedge reset_reg_clk) begin
        if (reset_reg_clk) begin
            r_ovf <= 1'b0;
        end else if (w_inc && w_sat && !i_clr) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/mtip_stat_regs.sv
// mtip_stat_regs: statistics / status register block on the reg_clk host bus.
//   Counts toggle-encoded MAC events in saturating counters, exposes synchronized
//   status levels, sticky W1C overflow flags and a small control register.
//   Optional build macro MTIP_STAT_SNAPSHOT_EN adds shadow registers loaded by
//   CTRL bit2; counter reads then return the shadow copy.
// Ports:
//   reg_clk, reset_reg_clk  register clock, async active-high reset
//   i_evt_tgl[NUM_CNT]      event toggles from rx/tx clock domains
//   i_status_in[16]         asynchronous status levels
//   i_reg_rd, i_reg_wr      access strobes, held until o_reg_busy falls
//   i_reg_addr[8]           word address
//   i_reg_data_in[32]       write data
//   o_reg_data_out[32]      registered read data
//   o_reg_busy              access in progress
module mtip_stat_regs
    import mtip_stat_pkg::*;
#(
    parameter int unsigned NUM_CNT     = 8,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               reg_clk,
    input  logic               reset_reg_clk,
    input  logic [NUM_CNT-1:0] i_evt_tgl,
    input  logic [15:0]        i_status_in,
    input  logic               i_reg_rd,
    input  logic               i_reg_wr,
    input  logic [7:0]         i_reg_addr,
    input  logic [31:0]        i_reg_data_in,
    output logic [31:0]        o_reg_data_out,
    output logic               o_reg_busy
);

    acc_state_e                        r_state;
    logic                              r_clr_on_read;
    logic [31:0]                       r_data_out;
    logic [SYNC_STAGES-1:0][15:0]      r_status_sync;

    logic [CNT_W-1:0]   w_cnt    [NUM_CNT];
    logic [CNT_W-1:0]   w_cnt_rd [NUM_CNT];
    logic [NUM_CNT-1:0] w_ovf;
    logic [NUM_CNT-1:0] w_clr;
    logic [NUM_CNT-1:0] w_ovf_clr;
    logic               w_rd;
    logic               w_wr;
    logic               w_clr_all;
    logic               w_snap;
    logic               w_in_cnt;
    logic [7:0]         w_cnt_off;
    logic [31:0]        w_rd_data;
    logic               w_unused_wdata;

    // Read wins over a simultaneous write; both act only in ACCESS.
    assign w_rd = (r_state == ACCESS) && i_reg_rd;
    assign w_wr = (r_state == ACCESS) && i_reg_wr && !i_reg_rd;

    assign w_unused_wdata = ^i_reg_data_in;

    always_ff @(posedge reg_clk or posedge reset_reg_clk) begin
        if (reset_reg_clk) begin
            r_status_sync <= '0;
        end else begin
            r_status_sync <= {r_status_sync[SYNC_STAGES-2:0], i_status_in};
        end
    end

    always_comb begin
        w_cnt_off = i_reg_addr - ADDR_CNT_BASE;
        w_in_cnt  = (i_reg_addr >= ADDR_CNT_BASE) && (w_cnt_off < 8'(NUM_CNT));
        w_clr_all = w_wr && (i_reg_addr == ADDR_CTRL) && i_reg_data_in[0];
`ifdef MTIP_STAT_SNAPSHOT_EN
        w_snap    = w_wr && (i_reg_addr == ADDR_CTRL) && i_reg_data_in[2];
`else
        w_snap    = 1'b0;
`endif
        w_ovf_clr = (w_wr && (i_reg_addr == ADDR_OVF)) ? i_reg_data_in[NUM_CNT-1:0] : '0;

        w_rd_data = '0;
        case (i_reg_addr)
            ADDR_ID:     w_rd_data = ID_VALUE;
            ADDR_STATUS: w_rd_data = {16'h0, r_status_sync[SYNC_STAGES-1]};
            ADDR_CTRL:   w_rd_data[1] = r_clr_on_read;
            ADDR_OVF:    w_rd_data[NUM_CNT-1:0] = w_ovf;
            default:     ;
        endcase

        for (int i = 0; i < NUM_CNT; i++) begin
            w_clr[i] = w_clr_all
                     | (w_rd && r_clr_on_read && w_in_cnt && (w_cnt_off == 8'(i)));
            if (w_in_cnt && (w_cnt_off == 8'(i))) begin
                w_rd_data[CNT_W-1:0] = w_cnt_rd[i];
            end
        end
    end

    always_ff @(posedge reg_clk or posedge reset_reg_clk) begin
        if (reset_reg_clk) begin
            r_state       <= IDLE;
            r_data_out    <= '0;
            r_clr_on_read <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_reg_rd || i_reg_wr) r_state <= ACCESS;
                end
                ACCESS: begin
                    r_state <= DONE;
                    if (w_rd) r_data_out <= w_rd_data;
                    if (w_wr && (i_reg_addr == ADDR_CTRL)) r_clr_on_read <= i_reg_data_in[1];
                end
                DONE: begin
                    if (!i_reg_rd && !i_reg_wr) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_reg_busy     = (i_reg_rd || i_reg_wr) && (r_state != DONE);
    assign o_reg_data_out = r_data_out;

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        mtip_stat_cnt #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cnt (
            .reg_clk       (reg_clk),
            .reset_reg_clk (reset_reg_clk),
            .i_evt_tgl     (i_evt_tgl[g]),
            .i_clr         (w_clr[g]),
            .i_ovf_clr     (w_ovf_clr[g]),
            .o_cnt         (w_cnt[g]),
            .o_ovf         (w_ovf[g])
        );
    end

`ifdef MTIP_STAT_SNAPSHOT_EN
    logic [CNT_W-1:0] r_shadow [NUM_CNT];

    always_ff @(posedge reg_clk or posedge reset_reg_clk) begin
        if (reset_reg_clk) begin
            for (int i = 0; i < NUM_CNT; i++) r_shadow[i] <= '0;
        end else if (w_snap) begin
            for (int i = 0; i < NUM_CNT; i++) r_shadow[i] <= w_cnt[i];
        end
    end

    assign w_cnt_rd = r_shadow;
`else
    assign w_cnt_rd = w_cnt;
`endif

endmodule

// File: tb/tb_mtip_stat_regs.sv
module tb_mtip_stat_regs;
    import mtip_stat_pkg::*;

    localparam int unsigned NUM_CNT = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned SYNC    = 2;

    logic               reg_clk = 1'b0;
    logic               reset_reg_clk = 1'b1;
    logic [NUM_CNT-1:0] i_evt_tgl = '0;
    logic [15:0]        i_status_in = '0;
    logic               i_reg_rd = 1'b0;
    logic               i_reg_wr = 1'b0;
    logic [7:0]         i_reg_addr = '0;
    logic [31:0]        i_reg_data_in = '0;
    logic [31:0]        o_reg_data_out;
    logic               o_reg_busy;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    string       name_q[$];

    mtip_stat_regs #(
        .NUM_CNT     (NUM_CNT),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .reg_clk        (reg_clk),
        .reset_reg_clk  (reset_reg_clk),
        .i_evt_tgl      (i_evt_tgl),
        .i_status_in    (i_status_in),
        .i_reg_rd       (i_reg_rd),
        .i_reg_wr       (i_reg_wr),
        .i_reg_addr     (i_reg_addr),
        .i_reg_data_in  (i_reg_data_in),
        .o_reg_data_out (o_reg_data_out),
        .o_reg_busy     (o_reg_busy)
    );

    initial forever #5 reg_clk = ~reg_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One bus access; returns read data ('x on busy timeout) and busy cycle count.
    task automatic bus_access(input logic rd, input logic wr, input logic [7:0] a,
                              input logic [31:0] wd, output logic [31:0] d, output int n);
        @(posedge reg_clk); #1;
        i_reg_rd = rd; i_reg_wr = wr; i_reg_addr = a; i_reg_data_in = wd;
        #1;
        n = 0;
        while (o_reg_busy === 1'b1 && n < 20) begin
            n++;
            @(posedge reg_clk); #1;
        end
        d = (n >= 20) ? 32'bx : o_reg_data_out;
        i_reg_rd = 1'b0; i_reg_wr = 1'b0;
        @(posedge reg_clk); #1;
    endtask

    // Issue a read and queue its expected value alongside the captured data.
    task automatic rd_push(input logic [7:0] a, input logic [31:0] e, input string nm);
        logic [31:0] d;
        int n;
        exp_q.push_back(e);
        name_q.push_back(nm);
        bus_access(1'b1, 1'b0, a, 32'h0, d, n);
        got_q.push_back(d);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] wd);
        logic [31:0] d;
        int n;
        bus_access(1'b0, 1'b1, a, wd, d, n);
    endtask

    // k events on channel ch, 4 cycles apart, plus settling time.
    task automatic evt(input int ch, input int k);
        repeat (k) begin
            @(posedge reg_clk); #1;
            i_evt_tgl[ch] = ~i_evt_tgl[ch];
            repeat (3) @(posedge reg_clk);
        end
        repeat (3) @(posedge reg_clk);
    endtask

    task automatic test_reset();
        logic [31:0] d, e, g;
        int n;
        string nm;
        reset_reg_clk = 1'b1;
        repeat (3) @(posedge reg_clk);
        #1;
        vectors++;
        if (o_reg_busy !== 1'b0 || o_reg_data_out !== 32'h0) begin
            $display("FAIL reset_outputs: busy=%b data=%h, want busy=0 data=0", o_reg_busy, o_reg_data_out);
            miscompares++;
        end
        reset_reg_clk = 1'b0;
        exp_q.push_back(ID_VALUE);
        name_q.push_back("id_read");
        bus_access(1'b1, 1'b0, ADDR_ID, 32'h0, d, n);
        got_q.push_back(d);
        vectors++;
        if (n !== 2) begin
            $display("FAIL id_busy_cycles: got %0d want 2", n);
            miscompares++;
        end
        for (int i = 0; i < NUM_CNT; i++) rd_push(ADDR_CNT_BASE + 8'(i), 32'h0, $sformatf("reset_cnt%0d", i));
        rd_push(8'h05, 32'h0, "unmapped_read");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
            vectors++;
            if (g !== e) begin
                $display("FAIL %s: got %h want %h", nm, g, e);
                miscompares++;
            end
        end
    endtask

    task automatic test_count();
        logic [31:0] e, g;
        string nm;
        evt(1, 5);
        rd_push(8'h11, 32'd5, "cnt1_five");
        rd_push(8'h10, 32'd0, "cnt0_idle");
        rd_push(8'h12, 32'd0, "cnt2_idle");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
            vectors++;
            if (g !== e) begin
                $display("FAIL %s: got %h want %h", nm, g, e);
                miscompares++;
            end
        end
    endtask

    task automatic test_saturate();
        logic [31:0] e, g;
        string nm;
        evt(0, 15);
        rd_push(8'h10, 32'hF, "cnt0_at_max");
        rd_push(ADDR_OVF, 32'h0, "ovf_before_sat");
        evt(0, 2);
        rd_push(8'h10, 32'hF, "cnt0_saturated");
        rd_push(ADDR_OVF, 32'h1, "ovf_set");
        bus_write(ADDR_OVF, 32'h1);
        rd_push(ADDR_OVF, 32'h0, "ovf_w1c");
        rd_push(8'h10, 32'hF, "cnt0_after_w1c");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
            vectors++;
            if (g !== e) begin
                $display("FAIL %s: got %h want %h", nm, g, e);
                miscompares++;
            end
        end
    endtask

    task automatic test_clr_on_read();
        logic [31:0] e, g;
        string nm;
        bus_write(ADDR_CTRL, 32'h2);
        rd_push(ADDR_CTRL, 32'h2, "ctrl_cor_set");
        evt(2, 3);
        rd_push(8'h12, 32'd3, "cor_first_read");
        rd_push(8'h12, 32'd0, "cor_reread");
        evt(2, 2);
        // Toggle one cycle before the strobe so the increment lands in ACCESS.
        @(posedge reg_clk); #1;
        i_evt_tgl[2] = ~i_evt_tgl[2];
        rd_push(8'h12, 32'd2, "cor_collide_read");
        rd_push(8'h12, 32'd1, "cor_event_kept");
        rd_push(8'h12, 32'd0, "cor_cleared");
        bus_write(ADDR_CTRL, 32'h0);
        rd_push(ADDR_CTRL, 32'h0, "ctrl_cor_off");
        bus_write(ADDR_CTRL, 32'h1);
        rd_push(8'h11, 32'd0, "clr_all_cnt1");
        rd_push(8'h10, 32'd0, "clr_all_cnt0");
        rd_push(ADDR_CTRL, 32'h0, "ctrl_clr_self");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
            vectors++;
            if (g !== e) begin
                $display("FAIL %s: got %h want %h", nm, g, e);
                miscompares++;
            end
        end
    endtask

    task automatic test_status_and_collision();
        logic [31:0] d, e, g;
        int n;
        string nm;
        i_status_in = 16'hA5A5;
        repeat (SYNC + 1) @(posedge reg_clk);
        rd_push(ADDR_STATUS, 32'h0000_A5A5, "status_a5a5");
        exp_q.push_back(32'h0);
        name_q.push_back("rdwr_read_served");
        bus_access(1'b1, 1'b1, ADDR_CTRL, 32'h2, d, n);
        got_q.push_back(d);
        rd_push(ADDR_CTRL, 32'h0, "rdwr_write_dropped");
        bus_write(8'h30, 32'hFFFF_FFFF);
        rd_push(8'h30, 32'h0, "unmapped_write");
        bus_write(ADDR_ID, 32'h0);
        rd_push(ADDR_ID, ID_VALUE, "id_readonly");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
            vectors++;
            if (g !== e) begin
                $display("FAIL %s: got %h want %h", nm, g, e);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] e, g;
        int n;
        string nm;
        evt(3, 2);
        @(posedge reg_clk); #1;
        i_reg_rd = 1'b1; i_reg_addr = 8'h13;
        @(posedge reg_clk); #1;
        reset_reg_clk = 1'b1;
        i_reg_rd = 1'b0;
        #1;
        vectors++;
        if (o_reg_busy !== 1'b0 || o_reg_data_out !== 32'h0) begin
            $display("FAIL reset_mid_outputs: busy=%b data=%h, want busy=0 data=0", o_reg_busy, o_reg_data_out);
            miscompares++;
        end
        @(posedge reg_clk); #1;
        reset_reg_clk = 1'b0;
        rd_push(8'h13, 32'd0, "cnt3_after_reset");
        // Strobe held across reset must start a fresh access afterwards.
        @(posedge reg_clk); #1;
        i_reg_rd = 1'b1; i_reg_addr = ADDR_ID;
        @(posedge reg_clk); #1;
        reset_reg_clk = 1'b1;
        @(posedge reg_clk); #1;
        reset_reg_clk = 1'b0;
        #1;
        n = 0;
        while (o_reg_busy === 1'b1 && n < 20) begin
            n++;
            @(posedge reg_clk); #1;
        end
        vectors++;
        if (n !== 2 || o_reg_data_out !== ID_VALUE) begin
            $display("FAIL held_strobe_fresh: cycles=%0d data=%h, want 2 and %h", n, o_reg_data_out, ID_VALUE);
            miscompares++;
        end
        i_reg_rd = 1'b0;
        @(posedge reg_clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
            vectors++;
            if (g !== e) begin
                $display("FAIL %s: got %h want %h", nm, g, e);
                miscompares++;
            end
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] e, g, snap_exp;
        string nm;
`ifdef MTIP_STAT_SNAPSHOT_EN
        snap_exp = 32'd3;
`else
        snap_exp = 32'd5;
`endif
        evt(4, 3);
        bus_write(ADDR_CTRL, 32'h4);
        evt(4, 2);
        rd_push(8'h14, snap_exp, "snapshot_cnt4");
        rd_push(ADDR_CTRL, 32'h0, "ctrl_snap_self");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = name_q.pop_front();
            vectors++;
            if (g !== e) begin
                $display("FAIL %s: got %h want %h", nm, g, e);
                miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_saturate();
        test_clr_on_read();
        test_status_and_collision();
        test_reset_mid_access();
        test_snapshot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
